// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin values, FSM state encoding and the
// one-hot coin encoding used by the change dispenser and the coin-accept FSM.
package vend_pkg;

   localparam int unsigned AMT_W  = 8;
   localparam int unsigned COIN_W = 3;

   // Coin values in cents
   localparam logic [AMT_W-1:0] VAL_Q = 8'd25;
   localparam logic [AMT_W-1:0] VAL_D = 8'd10;
   localparam logic [AMT_W-1:0] VAL_N = 8'd5;

   // State encoding
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_EJECT  = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERR    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_SELECT = S_SELECT,
      ST_EJECT  = S_EJECT,
      ST_DONE   = S_DONE,
      ST_ERR    = S_ERR
   } state_e;

   // One-hot coin encoding
   typedef logic [COIN_W-1:0] coin_oh_t;
   localparam coin_oh_t COIN_NONE = 3'b000;
   localparam coin_oh_t COIN_Q    = 3'b100;
   localparam coin_oh_t COIN_D    = 3'b010;
   localparam coin_oh_t COIN_N    = 3'b001;

   // Value in cents of a one-hot coin (0 for none/illegal)
   function automatic logic [AMT_W-1:0] coin_value(input coin_oh_t c);
      logic [AMT_W-1:0] v;
      v = '0;
      if (c == COIN_Q)      v = VAL_Q;
      else if (c == COIN_D) v = VAL_D;
      else if (c == COIN_N) v = VAL_N;
      return v;
   endfunction

endpackage

// File: rtl/change_coin_sel.sv
// Greedy coin selector: largest coin that fits in remaining and is in stock.
// Ports: remaining (cents owed), q/d/n_stock (stock counts) ->
//        coin_c (one-hot pick), none_c (no coin can be paid).
module change_coin_sel
   import vend_pkg::*;
#(
   parameter int unsigned STOCK_W = 4
) (
   input  logic [AMT_W-1:0]   remaining,
   input  logic [STOCK_W-1:0] q_stock,
   input  logic [STOCK_W-1:0] d_stock,
   input  logic [STOCK_W-1:0] n_stock,
   output coin_oh_t           coin_c,
   output logic               none_c
);

   // Priority 25c > 10c > 5c; a coin needs both value fit and nonzero stock
   always_comb begin
      coin_c = COIN_NONE;
      if ((remaining >= VAL_Q) && (q_stock != '0))      coin_c = COIN_Q;
      else if ((remaining >= VAL_D) && (d_stock != '0)) coin_c = COIN_D;
      else if ((remaining >= VAL_N) && (n_stock != '0)) coin_c = COIN_N;
      none_c = (coin_c == COIN_NONE);
   end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays an amount as one-cycle coin eject pulses, greedily
// from finite per-coin stocks, flagging err on invalid amount or short stock.
// Ports: clk_1Hz, clr (async, active-high); start/amount/refill requests
//        (IDLE only); busy, coin_q/d/n, done, err pulses; remaining cents;
//        q/d/n_stock counters. All outputs registered.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned MAX_AMOUNT = 35,
   parameter int unsigned Q_INIT     = 4,
   parameter int unsigned D_INIT     = 4,
   parameter int unsigned N_INIT     = 4,
   parameter int unsigned STOCK_W    = 4
) (
   input  logic               clk_1Hz,
   input  logic               clr,
   input  logic               start,
   input  logic [AMT_W-1:0]   amount,
   input  logic               refill,
   output logic               busy,
   output logic               coin_q,
   output logic               coin_d,
   output logic               coin_n,
   output logic               done,
   output logic               err,
   output logic [AMT_W-1:0]   remaining,
   output logic [STOCK_W-1:0] q_stock,
   output logic [STOCK_W-1:0] d_stock,
   output logic [STOCK_W-1:0] n_stock
);

   localparam logic [STOCK_W-1:0] Q_RST = STOCK_W'(Q_INIT);
   localparam logic [STOCK_W-1:0] D_RST = STOCK_W'(D_INIT);
   localparam logic [STOCK_W-1:0] N_RST = STOCK_W'(N_INIT);
   localparam logic [AMT_W-1:0]   MAX_AMT = AMT_W'(MAX_AMOUNT);

   state_e             state_q, state_d;
   logic [AMT_W-1:0]   remaining_q, remaining_d;
   logic [STOCK_W-1:0] q_stock_q, q_stock_d;
   logic [STOCK_W-1:0] d_stock_q, d_stock_d;
   logic [STOCK_W-1:0] n_stock_q, n_stock_d;
   coin_oh_t           coin_sel_q, coin_sel_d;
   logic               busy_q, busy_d;
   logic               coin_q_q, coin_q_d;
   logic               coin_d_q, coin_d_d;
   logic               coin_n_q, coin_n_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   coin_oh_t           pick_c;
   logic               none_c;
   logic               bad_amount_c;

   change_coin_sel #(.STOCK_W(STOCK_W)) u_sel (
      .remaining (remaining_q),
      .q_stock   (q_stock_q),
      .d_stock   (d_stock_q),
      .n_stock   (n_stock_q),
      .coin_c    (pick_c),
      .none_c    (none_c)
   );

   assign bad_amount_c = ((amount % VAL_N) != '0) || (amount > MAX_AMT);

   // Next-state, datapath and Moore output decode
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      q_stock_d   = q_stock_q;
      d_stock_d   = d_stock_q;
      n_stock_d   = n_stock_q;
      coin_sel_d  = coin_sel_q;

      case (state_q)
         ST_IDLE: begin
            if (refill) begin
               q_stock_d = Q_RST;
               d_stock_d = D_RST;
               n_stock_d = N_RST;
            end
            if (start) begin
               remaining_d = amount;
               state_d     = bad_amount_c ? ST_ERR : ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (remaining_q == '0) begin
               state_d = ST_DONE;
            end else if (none_c) begin
               state_d = ST_ERR;
            end else begin
               coin_sel_d = pick_c;
               state_d    = ST_EJECT;
            end
         end
         ST_EJECT: begin
            // Selector guaranteed value<=remaining and stock>0, so no wrap
            remaining_d = remaining_q - coin_value(coin_sel_q);
            if (coin_sel_q == COIN_Q) q_stock_d = q_stock_q - STOCK_W'(1);
            if (coin_sel_q == COIN_D) d_stock_d = d_stock_q - STOCK_W'(1);
            if (coin_sel_q == COIN_N) n_stock_d = n_stock_q - STOCK_W'(1);
            state_d = ST_SELECT;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d   = (state_d != ST_IDLE);
      coin_q_d = (state_d == ST_EJECT) && (coin_sel_d == COIN_Q);
      coin_d_d = (state_d == ST_EJECT) && (coin_sel_d == COIN_D);
      coin_n_d = (state_d == ST_EJECT) && (coin_sel_d == COIN_N);
      done_d   = (state_d == ST_DONE);
      err_d    = (state_d == ST_ERR);
   end

   // State and output registers
   always_ff @(posedge clk_1Hz or posedge clr) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         q_stock_q   <= Q_RST;
         d_stock_q   <= D_RST;
         n_stock_q   <= N_RST;
         coin_sel_q  <= COIN_NONE;
         busy_q      <= 1'b0;
         coin_q_q    <= 1'b0;
         coin_d_q    <= 1'b0;
         coin_n_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         q_stock_q   <= q_stock_d;
         d_stock_q   <= d_stock_d;
         n_stock_q   <= n_stock_d;
         coin_sel_q  <= coin_sel_d;
         busy_q      <= busy_d;
         coin_q_q    <= coin_q_d;
         coin_d_q    <= coin_d_d;
         coin_n_q    <= coin_n_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy      = busy_q;
   assign coin_q    = coin_q_q;
   assign coin_d    = coin_d_q;
   assign coin_n    = coin_n_q;
   assign done      = done_q;
   assign err       = err_q;
   assign remaining = remaining_q;
   assign q_stock   = q_stock_q;
   assign d_stock   = d_stock_q;
   assign n_stock   = n_stock_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser: default-stock instance (dut) and a
// stock-limited instance (dut2, Q/D/N = 1/3/0). Outputs sampled 1ns after
// each rising edge; flag vectors are {busy, coin_q, coin_d, coin_n, done, err}.
module tb_vend_change_dispenser;

   logic       clk_1Hz = 1'b0;
   logic       clr;
   logic       start,  refill;
   logic [7:0] amount;
   logic       start2, refill2;
   logic [7:0] amount2;

   logic       busy, coin_q, coin_d, coin_n, done, err;
   logic [7:0] remaining;
   logic [3:0] q_stock, d_stock, n_stock;
   logic       busy2, coin_q2, coin_d2, coin_n2, done2, err2;
   logic [7:0] remaining2;
   logic [3:0] q_stock2, d_stock2, n_stock2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_1Hz = ~clk_1Hz;

   vend_change_dispenser dut (
      .clk_1Hz(clk_1Hz), .clr(clr), .start(start), .amount(amount), .refill(refill),
      .busy(busy), .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
      .done(done), .err(err), .remaining(remaining),
      .q_stock(q_stock), .d_stock(d_stock), .n_stock(n_stock)
   );

   vend_change_dispenser #(.Q_INIT(1), .D_INIT(3), .N_INIT(0)) dut2 (
      .clk_1Hz(clk_1Hz), .clr(clr), .start(start2), .amount(amount2), .refill(refill2),
      .busy(busy2), .coin_q(coin_q2), .coin_d(coin_d2), .coin_n(coin_n2),
      .done(done2), .err(err2), .remaining(remaining2),
      .q_stock(q_stock2), .d_stock(d_stock2), .n_stock(n_stock2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] obs1();
      return {busy, coin_q, coin_d, coin_n, done, err};
   endfunction

   function automatic logic [5:0] obs2();
      return {busy2, coin_q2, coin_d2, coin_n2, done2, err2};
   endfunction

   task automatic tick();
      @(posedge clk_1Hz);
      #1;
   endtask

   // Present start for exactly one edge; returns 1ns after the accept edge
   task automatic accept(input logic [7:0] amt);
      start  = 1'b1;
      amount = amt;
      tick();
      start  = 1'b0;
      amount = 8'hxx;
   endtask

   task automatic accept2(input logic [7:0] amt, input logic with_refill);
      start2  = 1'b1;
      amount2 = amt;
      refill2 = with_refill;
      tick();
      start2  = 1'b0;
      refill2 = 1'b0;
      amount2 = 8'hxx;
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; refill = 1'b0; amount = 8'd0;
      start2 = 1'b0; refill2 = 1'b0; amount2 = 8'd0;
      #12;
      // Reset state
      chk("rst_flags", 32'(obs1()), 32'h00);
      chk("rst_rem",   32'(remaining), 32'd0);
      chk("rst_stock", 32'({q_stock, d_stock, n_stock}), 32'h444);
      chk("rst2_stock", 32'({q_stock2, d_stock2, n_stock2}), 32'h130);
      clr = 1'b0;
      tick();

      // 15c: dime, gap, nickel, done
      accept(8'd15);
      chk("t1_c0", 32'(obs1()), 32'b100000); tick();
      chk("t1_c1", 32'(obs1()), 32'b101000); tick();
      chk("t1_c2", 32'(obs1()), 32'b100000); tick();
      chk("t1_c3", 32'(obs1()), 32'b100100); tick();
      chk("t1_c4", 32'(obs1()), 32'b100000); tick();
      chk("t1_c5", 32'(obs1()), 32'b100010); tick();
      chk("t1_c6", 32'(obs1()), 32'b000000);
      chk("t1_stock", 32'({q_stock, d_stock, n_stock}), 32'h433);
      chk("t1_rem",   32'(remaining), 32'd0);

      // Refill in IDLE
      refill = 1'b1; tick(); refill = 1'b0;
      chk("refill_stock", 32'({q_stock, d_stock, n_stock}), 32'h444);
      chk("refill_busy",  32'(busy), 32'd0);

      // 35c (max): quarter then dime
      accept(8'd35);
      chk("t2_c0", 32'(obs1()), 32'b100000); tick();
      chk("t2_c1", 32'(obs1()), 32'b110000); tick();
      chk("t2_c2", 32'(obs1()), 32'b100000); tick();
      chk("t2_c3", 32'(obs1()), 32'b101000); tick();
      chk("t2_c4", 32'(obs1()), 32'b100000); tick();
      chk("t2_c5", 32'(obs1()), 32'b100010); tick();
      chk("t2_c6", 32'(obs1()), 32'b000000);
      chk("t2_stock", 32'({q_stock, d_stock, n_stock}), 32'h334);

      // Invalid amounts: not a multiple of 5, and above maximum
      accept(8'd7);
      chk("t3a_c0",  32'(obs1()), 32'b100001);
      chk("t3a_rem", 32'(remaining), 32'd7); tick();
      chk("t3a_c1",  32'(obs1()), 32'b000000);
      accept(8'd40);
      chk("t3b_c0",  32'(obs1()), 32'b100001);
      chk("t3b_rem", 32'(remaining), 32'd40); tick();
      chk("t3b_c1",  32'(obs1()), 32'b000000);
      chk("t3_stock", 32'({q_stock, d_stock, n_stock}), 32'h334);

      // Zero amount falls straight through SELECT to DONE
      accept(8'd0);
      chk("t0_c0", 32'(obs1()), 32'b100000); tick();
      chk("t0_c1", 32'(obs1()), 32'b100010); tick();
      chk("t0_c2", 32'(obs1()), 32'b000000);

      // Start and refill while busy are ignored
      accept(8'd15);
      chk("t6_c0", 32'(obs1()), 32'b100000); tick();
      chk("t6_c1", 32'(obs1()), 32'b101000);
      start = 1'b1; amount = 8'd5; refill = 1'b1;
      tick();
      start = 1'b0; refill = 1'b0;
      chk("t6_c2", 32'(obs1()), 32'b100000); tick();
      chk("t6_c3", 32'(obs1()), 32'b100100); tick();
      chk("t6_c4", 32'(obs1()), 32'b100000); tick();
      chk("t6_c5", 32'(obs1()), 32'b100010); tick();
      chk("t6_c6", 32'(obs1()), 32'b000000); tick();
      chk("t6_c7", 32'(obs1()), 32'b000000);
      chk("t6_stock", 32'({q_stock, d_stock, n_stock}), 32'h323);

      // Stock-limited greedy miss: 30c with Q/D/N=1/3/0
      accept2(8'd30, 1'b0);
      chk("t4_c0", 32'(obs2()), 32'b100000); tick();
      chk("t4_c1", 32'(obs2()), 32'b110000); tick();
      chk("t4_c2", 32'(obs2()), 32'b100000); tick();
      chk("t4_c3", 32'(obs2()), 32'b100001); tick();
      chk("t4_c4", 32'(obs2()), 32'b000000);
      chk("t4_rem",   32'(remaining2), 32'd5);
      chk("t4_stock", 32'({q_stock2, d_stock2, n_stock2}), 32'h030);

      // Refill with start on the same edge: first SELECT sees the quarter again
      accept2(8'd30, 1'b1);
      chk("t7_c0", 32'(obs2()), 32'b100000); tick();
      chk("t7_c1", 32'(obs2()), 32'b110000); tick();
      chk("t7_c2", 32'(obs2()), 32'b100000); tick();
      chk("t7_c3", 32'(obs2()), 32'b100001); tick();
      chk("t7_rem",   32'(remaining2), 32'd5);
      chk("t7_stock", 32'({q_stock2, d_stock2, n_stock2}), 32'h030);

      // Async clear during a quarter eject
      accept(8'd25);
      chk("t5_c0", 32'(obs1()), 32'b100000); tick();
      chk("t5_c1", 32'(obs1()), 32'b110000);
      #2 clr = 1'b1;
      #1;
      chk("t5_flags", 32'(obs1()), 32'b000000);
      chk("t5_rem",   32'(remaining), 32'd0);
      chk("t5_stock", 32'({q_stock, d_stock, n_stock}), 32'h444);
      #2 clr = 1'b0;
      tick();
      chk("t5_idle", 32'(obs1()), 32'b000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
